// File: rtl/clock_tick_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clock_tick_scheduler_pkg
// Description : Shared definitions for the tick scheduler: config FSM state
//               encodings and the tap-select clamp helper.
// Revision    : 1.0 - initial release
// ============================================================================
package clock_tick_scheduler_pkg;

  // Config FSM states; encodings are fixed so they read the same in waves.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    WAIT  = 2'd2
  } cfg_state_e;

  // Out-of-range taps saturate to the slowest legal tap.
  function automatic int clamp_tap(input int tap, input int width);
    return (tap >= width) ? (width - 1) : tap;
  endfunction

endpackage
`default_nettype wire

// File: rtl/clock_tick_channel.sv
`default_nettype none
// ============================================================================
// Module      : clock_tick_channel
// Description : One tick channel. Holds the enable/tap configuration and the
//               registered tick. tick_set is the combinational "tick will be
//               set at this edge" strobe, evaluated with the current (old)
//               configuration so a deferred update can land on it.
// Revision    : 1.0 - initial release
// ============================================================================
module clock_tick_channel
  import clock_tick_scheduler_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SELW  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] cnt_next,
  input  logic             apply,
  input  logic             new_en,
  input  logic [SELW-1:0]  new_tap,
  output logic             en,
  output logic             tick,
  output logic             tick_set
);

  localparam logic [SELW-1:0] C_TOP_TAP = SELW'(WIDTH - 1);

  logic             r_en;
  logic [SELW-1:0]  r_tap;
  logic             r_tick;
  logic [SELW-1:0]  w_shift;
  logic [WIDTH-1:0] w_low_mask;
  logic [WIDTH-1:0] w_tap_bit;

  // value mod 2^(t+1) == 2^t  <=>  bits [t:0] of the value equal 1 << t
  assign w_shift    = C_TOP_TAP - r_tap;
  assign w_low_mask = {WIDTH{1'b1}} >> w_shift;
  assign w_tap_bit  = {{(WIDTH-1){1'b0}}, 1'b1} << r_tap;
  assign tick_set   = r_en & ((cnt_next & w_low_mask) == w_tap_bit);

  // Tick register follows the old config; apply only affects later edges.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_en   <= 1'b0;
      r_tap  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_tick <= tick_set;
      if (apply) begin
        r_en  <= new_en;
        r_tap <= new_tap;
      end
    end
  end

  assign en   = r_en;
  assign tick = r_tick;

endmodule
`default_nettype wire

// File: rtl/clock_tick_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : clock_tick_scheduler
// Description : Multi-channel tick-enable generator. A free-running prescaler
//               counter feeds per-channel tap comparators; a small config FSM
//               accepts valid/ready writes and defers tap changes on active
//               channels to their next tick boundary.
// Revision    : 1.0 - initial release
// ============================================================================
module clock_tick_scheduler
  import clock_tick_scheduler_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4,
  parameter int SELW     = $clog2(WIDTH),
  parameter int CHW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CHW-1:0]      cfg_channel,
  input  logic [SELW-1:0]     cfg_tap,
  input  logic                cfg_enable,
  input  logic                sync_restart,
  output logic [CHANNELS-1:0] tick,
  output logic [WIDTH-1:0]    prescaler_value,
  output logic                busy
);

  logic [WIDTH-1:0]    r_cnt;
  logic [WIDTH-1:0]    w_cnt_next;
  cfg_state_e          r_state;
  logic                r_cfg_ready;
  logic [CHW-1:0]      r_ch;
  logic [SELW-1:0]     r_tap;
  logic                r_en;
  logic [CHANNELS-1:0] w_ch_en;
  logic [CHANNELS-1:0] w_tick_set;
  logic [CHANNELS-1:0] w_apply_vec;
  logic [CHANNELS-1:0] w_tick;
  logic                w_target_en;
  logic                w_target_tick_set;
  logic                w_apply;
  logic                w_cfg_in_range;

  // Restart wins over increment; the channels compare against this value.
  assign w_cnt_next = sync_restart ? '0 : r_cnt + 1'b1;

  // Free-running prescaler with synchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_next;
    end
  end

  // The pending config lands on the old config's tick (or a restart edge).
  assign w_apply = (r_state == APPLY) ||
                   ((r_state == WAIT) && (w_target_tick_set || sync_restart));

  assign w_cfg_in_range = int'(cfg_channel) < CHANNELS;

  // Channel select muxes and per-channel apply decode.
  always_comb begin
    w_target_en       = 1'b0;
    w_target_tick_set = 1'b0;
    w_apply_vec       = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (int'(cfg_channel) == c) w_target_en = w_ch_en[c];
      if (int'(r_ch) == c) begin
        w_target_tick_set = w_tick_set[c];
        w_apply_vec[c]    = w_apply;
      end
    end
  end

  // Config FSM: latch request, then apply immediately or at the tick boundary.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cfg_ready <= 1'b1;
      r_ch        <= '0;
      r_tap       <= '0;
      r_en        <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          // Out-of-range channels are consumed without touching anything.
          if (cfg_valid && r_cfg_ready && w_cfg_in_range) begin
            r_ch        <= cfg_channel;
            r_tap       <= SELW'(clamp_tap(int'(cfg_tap), WIDTH));
            r_en        <= cfg_enable;
            r_cfg_ready <= 1'b0;
            if (!w_target_en || !cfg_enable) begin
              r_state <= APPLY;
            end else begin
              r_state <= WAIT;
            end
          end
        end
        APPLY: begin
          r_state     <= IDLE;
          r_cfg_ready <= 1'b1;
        end
        WAIT: begin
          if (w_target_tick_set || sync_restart) begin
            r_state     <= IDLE;
            r_cfg_ready <= 1'b1;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_cfg_ready <= 1'b1;
        end
      endcase
    end
  end

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_channel
      clock_tick_channel #(
        .WIDTH (WIDTH),
        .SELW  (SELW)
      ) u_channel (
        .clk      (clk),
        .reset    (reset),
        .cnt_next (w_cnt_next),
        .apply    (w_apply_vec[gi]),
        .new_en   (r_en),
        .new_tap  (r_tap),
        .en       (w_ch_en[gi]),
        .tick     (w_tick[gi]),
        .tick_set (w_tick_set[gi])
      );
    end
  endgenerate

  assign tick            = w_tick;
  assign prescaler_value = r_cnt;
  assign cfg_ready       = r_cfg_ready;
  assign busy            = ~r_cfg_ready;

endmodule
`default_nettype wire
